// File: rtl/xform_fifo_stage.sv
// xform_fifo_stage: valid/ready transform stage with a DEPTH-entry output FIFO.
// Each accepted beat is transformed by in_mode and stored as {ovf, data}.
// Optional statistics counters are built when XFORM_FIFO_STATS_EN is defined.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  producer handshake (in_ready depends on registered state only)
//   in_data, in_mode   beat payload and transform select
//   out_ready/out_valid consumer handshake
//   out_data, out_ovf  head entry (zero when out_valid=0)
//   level              occupancy 0..DEPTH
//   stat_beats         (XFORM_FIFO_STATS_EN) accepted beats, wrapping
//   stat_ovf           (XFORM_FIFO_STATS_EN) accepted beats with ovf=1, saturating
module xform_fifo_stage #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADD_CONST = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [1:0]                in_mode,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_ovf,
  output logic [$clog2(DEPTH):0]    level
`ifdef XFORM_FIFO_STATS_EN
  ,
  output logic [31:0]               stat_beats,
  output logic [15:0]               stat_ovf
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_W + 1;
  localparam logic [DATA_W-1:0] K = DATA_W'(ADD_CONST);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_count;

  logic [ENT_W-1:0] w_sum;
  logic [ENT_W-1:0] w_sum_inv;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_head;
  logic             w_push;
  logic             w_pop;

  // Handshake flags; in_ready never looks at out_ready.
  assign in_ready  = rst_n && (r_count < LVL_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign level     = r_count;

  // Head entry, zeroed while the FIFO is empty.
  assign w_head   = r_mem[r_rptr];
  assign out_data = out_valid ? w_head[DATA_W-1:0] : '0;
  assign out_ovf  = out_valid ? w_head[DATA_W] : 1'b0;

  // Transform on a DATA_W+1 bit sum; the top bit of the entry is the ovf flag.
  always_comb begin
    w_sum     = {1'b0, in_data} + {1'b0, K};
    w_sum_inv = {1'b0, ~in_data} + {1'b0, K};
    w_entry   = {1'b0, in_data};
    case (in_mode)
      2'b01:   w_entry = w_sum_inv;
      2'b10:   w_entry = w_sum[DATA_W] ? {1'b1, {DATA_W{1'b1}}} : w_sum;
      2'b11:   w_entry = {1'b0, ~in_data};
      default: w_entry = {1'b0, in_data};
    endcase
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef XFORM_FIFO_STATS_EN
  logic [31:0] r_stat_beats;
  logic [15:0] r_stat_ovf;

  // Beat counter wraps; overflow counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_beats <= '0;
      r_stat_ovf   <= '0;
    end else if (w_push) begin
      r_stat_beats <= r_stat_beats + 32'd1;
      if (w_entry[DATA_W] && (r_stat_ovf != 16'hFFFF)) begin
        r_stat_ovf <= r_stat_ovf + 16'd1;
      end
    end
  end

  assign stat_beats = r_stat_beats;
  assign stat_ovf   = r_stat_ovf;
`endif

endmodule
